// File: rtl/pattern_counter_pkg.sv
// Shared types and parameter limits for the serial pattern counter.
package pattern_counter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFill  = 2'd1,
    StArmed = 2'd2
  } pc_state_e;

  localparam int unsigned PatWMin = 1;
  localparam int unsigned PatWMax = 32;
  localparam int unsigned CntWMin = 2;
  localparam int unsigned CntWMax = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating match counter with a sticky flag set on reaching all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o,
  output logic             sat_o
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0] count_q, count_d;
  logic             sat_q, sat_d;

  always_comb begin
    count_d = count_q;
    sat_d   = sat_q;
    if (clr_i) begin
      // Clear wins, but a coincident increment still counts as the first event.
      count_d = {{(CNT_W-1){1'b0}}, inc_i};
      sat_d   = 1'b0;
    end else if (inc_i && (count_q != CntMax)) begin
      count_d = count_q + 1'b1;
      if (count_d == CntMax) begin
        sat_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  assign count_o = count_q;
  assign sat_o   = sat_q;

endmodule

// File: rtl/pattern_counter.sv
// Serial pattern counter: matches a programmable PAT_W-bit pattern in a qualified
// bit stream and counts occurrences, with overlapping or non-overlapping detection.
module pattern_counter
  import pattern_counter_pkg::*;
#(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cfg_load_i,
  input  logic [PAT_W-1:0] cfg_pattern_i,
  input  logic             cfg_overlap_i,
  input  logic             cnt_clr_i,
  input  logic             in_valid_i,
  input  logic             cin_i,
  output logic             match_o,
  output logic [CNT_W-1:0] count_o,
  output logic             sat_o,
  output logic             armed_o
);

  localparam int unsigned     FillW    = $clog2(PAT_W + 1);
  localparam logic [FillW-1:0] FillLast = FillW'(PAT_W - 1);
  localparam logic [FillW-1:0] FillFull = FillW'(PAT_W);

  if (PAT_W < PatWMin || PAT_W > PatWMax) begin : gen_bad_pat_w
    $error("PAT_W out of range");
  end
  if (CNT_W < CntWMin || CNT_W > CntWMax) begin : gen_bad_cnt_w
    $error("CNT_W out of range");
  end

  pc_state_e        state_q, state_d;
  logic [PAT_W-1:0] pattern_q, pattern_d;
  logic             overlap_q, overlap_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [PAT_W-1:0] hist_shift;
  logic [FillW-1:0] fill_q, fill_d;
  logic             match_q, match_d;
  logic             armed_q;
  logic             cnt_clr, cnt_inc;

  if (PAT_W == 1) begin : gen_hist_1
    assign hist_shift = cin_i;
  end else begin : gen_hist_n
    assign hist_shift = {hist_q[PAT_W-2:0], cin_i};
  end

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    overlap_d = overlap_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    match_d   = 1'b0;
    cnt_clr   = cnt_clr_i;
    cnt_inc   = 1'b0;

    if (cfg_load_i) begin
      // Reload restarts detection; a bit arriving in the same cycle is dropped.
      pattern_d = cfg_pattern_i;
      overlap_d = cfg_overlap_i;
      hist_d    = '0;
      fill_d    = '0;
      cnt_clr   = 1'b1;
      state_d   = StFill;
    end else if (in_valid_i) begin
      unique case (state_q)
        StIdle: ;
        StFill: begin
          hist_d = hist_shift;
          if (fill_q == FillLast) begin
            fill_d  = FillFull;
            state_d = StArmed;
            match_d = (hist_shift == pattern_q);
          end else begin
            fill_d = fill_q + 1'b1;
          end
        end
        StArmed: begin
          hist_d  = hist_shift;
          match_d = (hist_shift == pattern_q);
        end
        default: state_d = StIdle;
      endcase

      if (match_d) begin
        cnt_inc = 1'b1;
        if (!overlap_q) begin
          // Non-overlapping: the matched bits may not start the next occurrence.
          fill_d  = '0;
          state_d = StFill;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      pattern_q <= '0;
      overlap_q <= 1'b0;
      hist_q    <= '0;
      fill_q    <= '0;
      match_q   <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      overlap_q <= overlap_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      armed_q   <= (state_d == StArmed);
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_sat_counter (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (cnt_clr),
    .inc_i   (cnt_inc),
    .count_o (count_o),
    .sat_o   (sat_o)
  );

  assign match_o = match_q;
  assign armed_o = armed_q;

endmodule

// File: tb/tb_pattern_counter.sv
// Bench for pattern_counter: two instances (CNT_W=8 and CNT_W=2) share one stimulus stream.
module tb_pattern_counter;

  logic       clk, rst_n;
  logic       cfg_load, cfg_overlap, cnt_clr, in_valid, cin;
  logic [3:0] cfg_pattern;
  logic       match_a, sat_a, armed_a;
  logic [7:0] count_a;
  logic       match_b, sat_b, armed_b;
  logic [1:0] count_b;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       ld;
    logic [3:0] pat;
    logic       ovl;
    logic       clr;
    logic       vld;
    logic       bit_v;
    logic       m;
    logic [7:0] c;
    logic       a;
    logic       chk_b;
    logic [1:0] cb;
    logic       sb;
  } vec_t;

  typedef struct {
    string      tag;
    logic       m;
    logic [7:0] c;
    logic       a;
    logic       chk_b;
    logic [1:0] cb;
    logic       sb;
  } exp_t;

  vec_t tbl[$];
  exp_t sb_q[$];

  pattern_counter #(.PAT_W(4), .CNT_W(8)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .cfg_load_i(cfg_load), .cfg_pattern_i(cfg_pattern),
    .cfg_overlap_i(cfg_overlap), .cnt_clr_i(cnt_clr), .in_valid_i(in_valid), .cin_i(cin),
    .match_o(match_a), .count_o(count_a), .sat_o(sat_a), .armed_o(armed_a)
  );

  pattern_counter #(.PAT_W(4), .CNT_W(2)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .cfg_load_i(cfg_load), .cfg_pattern_i(cfg_pattern),
    .cfg_overlap_i(cfg_overlap), .cnt_clr_i(cnt_clr), .in_valid_i(in_valid), .cin_i(cin),
    .match_o(match_b), .count_o(count_b), .sat_o(sat_b), .armed_o(armed_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(logic ld, logic [3:0] pat, logic ovl, logic clr, logic vld,
                              logic b, logic m, logic [7:0] c, logic a);
    vec_t v;
    v.ld = ld; v.pat = pat; v.ovl = ovl; v.clr = clr; v.vld = vld; v.bit_v = b;
    v.m = m; v.c = c; v.a = a; v.chk_b = 1'b0; v.cb = '0; v.sb = 1'b0;
    return v;
  endfunction

  function automatic vec_t mkb(logic ld, logic [3:0] pat, logic clr, logic vld, logic b,
                               logic m, logic [7:0] c, logic a, logic [1:0] cb, logic sb);
    vec_t v;
    v = mk(ld, pat, 1'b1, clr, vld, b, m, c, a);
    v.chk_b = 1'b1; v.cb = cb; v.sb = sb;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    cfg_load = v.ld; cfg_pattern = v.pat; cfg_overlap = v.ovl;
    cnt_clr = v.clr; in_valid = v.vld; cin = v.bit_v;
    e.tag = tag; e.m = v.m; e.c = v.c; e.a = v.a;
    e.chk_b = v.chk_b; e.cb = v.cb; e.sb = v.sb;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, " scoreboard"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({e.tag, " match"}, 32'(match_a), 32'(e.m));
      check({e.tag, " count"}, 32'(count_a), 32'(e.c));
      check({e.tag, " armed"}, 32'(armed_a), 32'(e.a));
      check({e.tag, " sat"}, 32'(sat_a), 32'd0);
      if (e.chk_b) begin
        check({e.tag, " match_b"}, 32'(match_b), 32'(e.m));
        check({e.tag, " count_b"}, 32'(count_b), 32'(e.cb));
        check({e.tag, " sat_b"}, 32'(sat_b), 32'(e.sb));
        check({e.tag, " armed_b"}, 32'(armed_b), 32'(e.a));
      end
    end
    cfg_load = 1'b0; cnt_clr = 1'b0; in_valid = 1'b0; cin = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " match"}, 32'(match_a), 32'd0);
    check({tag, " count"}, 32'(count_a), 32'd0);
    check({tag, " sat"}, 32'(sat_a), 32'd0);
    check({tag, " armed"}, 32'(armed_a), 32'd0);
    check({tag, " count_b"}, 32'(count_b), 32'd0);
    check({tag, " sat_b"}, 32'(sat_b), 32'd0);
  endtask

  initial begin
    logic [3:0] p;
    p = 4'b1010;
    // Idle: no pattern loaded, stream ignored.
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    // Overlapping 1010 over 10101010: hits on bits 4, 6, 8.
    tbl.push_back(mk(1, p, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 2, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 2, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 3, 1));
    // Non-overlapping: hits on bits 4 and 8 only, then 1111 arms without a hit.
    tbl.push_back(mk(1, p, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 2, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 2, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 2, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 2, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 2, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1));
    // Gaps of three idle cycles between valid bits.
    tbl.push_back(mk(1, p, 1, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) begin
      tbl.push_back(mk(0, 0, 0, 0, 1, p[3-i], (i == 3), (i == 3) ? 8'd1 : 8'd0, (i == 3)));
      if (i < 3) begin
        for (int j = 0; j < 3; j++) tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
      end
    end
    // Load coincident with the completing bit: bit dropped, fill restarts.
    tbl.push_back(mk(1, p, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, p, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 1, 1));

    cfg_load = 0; cfg_pattern = 0; cfg_overlap = 0; cnt_clr = 0; in_valid = 0; cin = 0;
    rst_n = 1'b0;
    #12;
    check_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Saturation on the CNT_W=2 instance, then clear coincident with a match.
    apply(mkb(1, 4'b1111, 0, 0, 0, 0, 0, 0, 0, 0), "sat_load");
    apply(mkb(0, 0, 0, 1, 1, 0, 0, 0, 0, 0), "sat_b1");
    apply(mkb(0, 0, 0, 1, 1, 0, 0, 0, 0, 0), "sat_b2");
    apply(mkb(0, 0, 0, 1, 1, 0, 0, 0, 0, 0), "sat_b3");
    apply(mkb(0, 0, 0, 1, 1, 1, 1, 1, 1, 0), "sat_b4");
    apply(mkb(0, 0, 0, 1, 1, 1, 2, 1, 2, 0), "sat_b5");
    apply(mkb(0, 0, 0, 1, 1, 1, 3, 1, 3, 1), "sat_b6");
    apply(mkb(0, 0, 0, 1, 1, 1, 4, 1, 3, 1), "sat_b7");
    apply(mkb(0, 0, 1, 1, 1, 1, 1, 1, 1, 0), "sat_clr");
    apply(mkb(0, 0, 0, 1, 1, 1, 2, 1, 2, 0), "sat_b9");

    // Asynchronous reset mid-pattern returns to idle; later bits never match.
    apply(mk(1, p, 1, 0, 0, 0, 0, 0, 0), "rst_load");
    apply(mk(0, 0, 0, 0, 1, 1, 0, 0, 0), "rst_b1");
    apply(mk(0, 0, 0, 0, 1, 0, 0, 0, 0), "rst_b2");
    apply(mk(0, 0, 0, 0, 1, 1, 0, 0, 0), "rst_b3");
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("mid_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply(mk(0, 0, 0, 0, 1, 0, 0, 0, 0), "idle_b4");
    for (int i = 0; i < 4; i++) apply(mk(0, 0, 0, 0, 1, p[3-i], 0, 0, 0), $sformatf("idle%0d", i));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
